// File: rtl/agc_zc_period_meter.sv
// agc_zc_period_meter
// A hysteresis comparator finds rising zero crossings in the AGC output stream.
// The block counts the enabled samples between consecutive crossings.
// That count is the instantaneous-period estimate used by the FM demodulator.
// Optional build macro ZC_PERIOD_AVG_EN reports the mean of the last four raw
// periods instead of each raw period.
module agc_zc_period_meter #(
   parameter int          IN_W  = 39,
   parameter logic [63:0] HYST  = 64'd8589934592,
   parameter int          CNT_W = 16
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    clk_enable,
   input  logic signed [IN_W-1:0]  din,
   output logic [CNT_W-1:0]        period,
   output logic                    period_valid,
   output logic                    timeout,
   output logic                    pol
);

   typedef enum logic [1:0] {ST_UNK, ST_NEG, ST_POS} state_t;

   localparam logic signed [IN_W-1:0] HYST_P  = HYST[IN_W-1:0];
   localparam logic signed [IN_W-1:0] HYST_N  = -HYST_P;
   localparam logic [CNT_W-1:0]       CNT_MAX = '1;

   state_t           state;
   state_t           state_nx;
   logic             above;
   logic             below;
   logic             rise;
   logic             synced;
   logic [CNT_W-1:0] cnt;
   logic             period_evt;
   logic             tout_evt;

   // Counter increment that sticks at full scale instead of wrapping
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      if (v == CNT_MAX) begin
         return v;
      end
      return v + 1'b1;
   endfunction

   // Comparator next state; a rising crossing is only a NEG to POS move
   always_comb begin
      above    = (din >= HYST_P);
      below    = (din <= HYST_N);
      state_nx = state;
      rise     = 1'b0;
      case (state)
         ST_UNK: begin
            if (above) begin
               state_nx = ST_POS;
            end else if (below) begin
               state_nx = ST_NEG;
            end
         end
         ST_NEG: begin
            if (above) begin
               state_nx = ST_POS;
               rise     = 1'b1;
            end
         end
         ST_POS: begin
            if (below) begin
               state_nx = ST_NEG;
            end
         end
         default: state_nx = ST_UNK;
      endcase
   end

   // Measurement events on this enabled sample; a crossing beats saturation
   always_comb begin
      period_evt = clk_enable & rise & synced;
      tout_evt   = clk_enable & ~rise & synced & (cnt == CNT_MAX);
   end

   // Comparator state and registered polarity output
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= ST_UNK;
         pol   <= 1'b0;
      end else if (clk_enable) begin
         state <= state_nx;
         pol   <= (state_nx == ST_POS);
      end
   end

   // Sample counter, synchronisation flag and sticky timeout
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt     <= '0;
         synced  <= 1'b0;
         timeout <= 1'b0;
      end else if (clk_enable) begin
         if (rise) begin
            cnt     <= {{(CNT_W-1){1'b0}}, 1'b1};
            synced  <= 1'b1;
            timeout <= 1'b0;
         end else begin
            cnt <= sat_inc(cnt);
            if (tout_evt) begin
               timeout <= 1'b1;
               synced  <= 1'b0;
            end
         end
      end
   end

`ifdef ZC_PERIOD_AVG_EN
   logic [3:0][CNT_W-1:0] hist;
   logic [2:0]            nhist;
   logic [CNT_W+1:0]      sum;
   logic [CNT_W+1:0]      sum_nx;

   // Running sum over the last four raw periods; the oldest drops out once full
   always_comb begin
      sum_nx = sum + {2'b00, cnt};
      if (nhist == 3'd4) begin
         sum_nx = sum_nx - {2'b00, hist[3]};
      end
   end

   // Averaged period output; history restarts after reset or timeout
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         hist         <= '0;
         nhist        <= '0;
         sum          <= '0;
         period       <= '0;
         period_valid <= 1'b0;
      end else begin
         period_valid <= 1'b0;
         if (tout_evt) begin
            hist  <= '0;
            nhist <= '0;
            sum   <= '0;
         end else if (period_evt) begin
            hist  <= {hist[2:0], cnt};
            sum   <= sum_nx;
            nhist <= (nhist == 3'd4) ? 3'd4 : nhist + 3'd1;
            if (nhist >= 3'd3) begin
               period       <= sum_nx[CNT_W+1:2];
               period_valid <= 1'b1;
            end
         end
      end
   end
`else
   // Raw period output, updated on every synchronised rising crossing
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         period       <= '0;
         period_valid <= 1'b0;
      end else begin
         period_valid <= 1'b0;
         if (period_evt) begin
            period       <= cnt;
            period_valid <= 1'b1;
         end
      end
   end
`endif

endmodule

// File: doc/agc_zc_period_meter.md
# agc_zc_period_meter

Downstream consumer of the AGC stage. Takes the AGC's normalised real output sample stream (sfix39_En36). It finds rising zero crossings with a hysteresis comparator and measures the number of enabled samples between consecutive crossings. That period is the instantaneous-frequency estimate used by the FM demodulation path that follows. Sampling is qualified by the same `clk_enable` strobe that drives the AGC.

## Interface
Parameters:
- `IN_W`, default 39: input sample width (signed, En36).
- `HYST`, default 2^33 (0.125 in En36): hysteresis threshold in input LSBs. Must be positive and below 2^(IN_W-1).
- `CNT_W`, default 16: period counter and output width.

Ports:
- `clk`  in  1  single clock; all logic is on its rising edge.
- `reset`  in  1  asynchronous, active-low reset. Asserted when 0.
- `clk_enable`  in  1  sample qualifier. When 0, all state holds.
- `din`  in  IN_W  signed AGC output sample, sfix39_En36.
- `period`  out  CNT_W  last measured period in samples (unsigned).
- `period_valid`  out  1  one-cycle pulse when `period` is updated.
- `timeout`  out  1  no rising crossing seen within 2^CNT_W-1 samples. Sticky until the next rising crossing.
- `pol`  out  1  current comparator state: 1 = POS, 0 = NEG or UNK.

## Operation
- Comparator FSM, advanced only when `clk_enable`=1:
  - UNK (the reset state):
    - `din` >= +HYST → POS, with no crossing event.
    - `din` <= -HYST → NEG.
    - Otherwise stay in UNK.
  - NEG:
    - `din` >= +HYST → POS and a rising-crossing event.
    - Otherwise stay in NEG.
  - POS:
    - `din` <= -HYST → NEG.
    - Otherwise stay in POS.
  - Comparisons are full-width signed. Samples strictly inside (-HYST, +HYST) never change state.
- Synchronisation flag `synced`, reset to 0:
  - First rising crossing with `synced`=0: load `cnt`=1, set `synced`=1, no output.
  - Rising crossing with `synced`=1: `period` <= `cnt`, pulse `period_valid`, load `cnt`=1.
  - Non-crossing enabled sample: `cnt` <= `cnt`+1.
- Period semantics: crossings at enabled-sample indices i and j give `period` = j-i.
- Timeout:
  - Applies when `synced`=1 and `cnt` reaches 2^CNT_W-1.
  - Set `timeout`=1 and clear `synced`. `cnt` saturates and never wraps.
  - The next rising crossing clears `timeout` and re-arms the meter as a first crossing, producing no `period`.
- Simultaneous crossing and saturation on the same sample: the crossing wins. `period` = 2^CNT_W-1 and `timeout` stays 0.
- `clk_enable`=0 cycles are not counted. Sample index counts enabled cycles only.

## Timing
- Reset values:
  - Outputs: `period`=0, `period_valid`=0, `timeout`=0, `pol`=0.
  - Internal: FSM=UNK, `synced`=0, `cnt`=0.
- Latency: `period_valid`, `period`, `timeout` and `pol` are registered. They update at the rising edge that samples the qualifying `din` with `clk_enable`=1.
- `period_valid` is high for exactly one clock. It is 0 on any cycle whose preceding edge had `clk_enable`=0.
- `period` holds its value between pulses.
- Reset asserted mid-measurement discards everything. After release, the first rising crossing only re-arms.

## Configuration
- `ZC_PERIOD_AVG_EN` defined:
  - `period` is the mean of the last 4 raw periods: a (CNT_W+2)-bit running sum shifted right by 2, truncated.
  - `period_valid` pulses only once 4 raw periods have been collected since reset or the last timeout. The history is cleared on timeout.
  - Latency is unchanged.
- Not defined: `period` is the raw period as above.

## Test plan
- **Square wave:** ±0.5 with a 20-sample period and `clk_enable`=1 continuously.
  - First rising crossing gives no pulse.
  - Each subsequent one gives `period_valid` with `period`=20.
  - `pol` toggles every 10 samples.
- **Hysteresis:** alternating +0.1/-0.1 after syncing on a ±0.5 wave.
  - No `period_valid` and `pol` unchanged.
  - Resuming ±0.5 with period 16 yields `period` = elapsed samples since the last crossing, then 16 thereafter.
- **Enable gaps:** 20-sample ±0.5 wave with `clk_enable` low 1 cycle in 3. `period` stays 20.
- **Timeout:** after sync, hold `din`=+0.5 for 65535 enabled samples.
  - `timeout`=1 on the 65535th sample.
  - A later rising crossing clears `timeout` with no pulse.
  - The following crossing reports a normal period.
- **Reset mid-run:** assert `reset`=0 for 3 cycles while `cnt`=7.
  - All outputs return to 0 and the FSM returns to UNK.
  - A 12-sample wave then gives its first pulse on the second rising crossing, with `period`=12.
- **`ZC_PERIOD_AVG_EN` build:** raw periods 10, 12, 14, 16 give a single pulse with `period`=13. A fifth raw period of 20 gives `period`=15.
